bcd_updown_counter_n: RTL

BCD_UPDOWN_COUNTER_N -- requirements
Module: bcd_updown_counter_n

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_updown_counter_n_if.sv | 27 ++
 rtl/bcd_digit_cell.sv | 55 +++++
 rtl/bcd_updown_counter_n.sv | 95 +++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the BCD counter family.
// Contents: digit width, the largest legal digit value, the legal digit-count range,
// a digit type, and helpers that detect and clamp out-of-range digits.
package bcd_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned NDIG_MIN = 1;
    localparam int unsigned NDIG_MAX = 8;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // A 4-bit code above 9 is not a valid BCD digit.
    function automatic logic bcd_invalid(input bcd_digit_t d);
        return (d > BCD_MAX);
    endfunction

    // Out-of-range load digits are stored as 9.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return bcd_invalid(d) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_n_if.sv
// Control/data bundle for bcd_updown_counter_n.
// Signals:
//   en, up, load, load_val : driven by the master (user logic)
//   digits, tc, load_err, is_zero : driven by the slave (the counter)
// load_val/digits pack digit 0 in bits [3:0].
interface bcd_updown_counter_n_if #(
    parameter int unsigned NDIG = 4
);
    logic              en;
    logic              up;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic [4*NDIG-1:0] digits;
    logic              tc;
    logic              load_err;
    logic              is_zero;

    modport master (
        output en, up, load, load_val,
        input  digits, tc, load_err, is_zero
    );

    modport slave (
        input  en, up, load, load_val,
        output digits, tc, load_err, is_zero
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// Single registered BCD digit with parallel load and carry/borrow-gated stepping.
// Ports:
//   clock, rst : clock, synchronous active-high reset (digit -> 0)
//   i_inc      : count-up request for the whole counter this cycle
//   i_dec      : count-down request for the whole counter this cycle
//   i_load     : load i_ld_val (clamped to 9); has priority over stepping
//   i_ld_val   : load digit
//   i_max_in   : carry-in, all lower digits are at 9
//   i_min_in   : borrow-in, all lower digits are at 0
//   o_digit    : registered digit
//   o_at_max   : digit is 9
//   o_at_min   : digit is 0
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_load,
    input  bcd_digit_t i_ld_val,
    input  logic       i_max_in,
    input  logic       i_min_in,
    output bcd_digit_t o_digit,
    output logic       o_at_max,
    output logic       o_at_min
);

    bcd_digit_t r_digit;
    bcd_digit_t w_digit_next;

    always_comb begin
        w_digit_next = r_digit;
        if (i_load) begin
            w_digit_next = bcd_clamp(i_ld_val);
        end else if (i_inc && i_max_in) begin
            w_digit_next = (r_digit >= BCD_MAX) ? '0 : r_digit + 4'd1;
        end else if (i_dec && i_min_in) begin
            w_digit_next = (r_digit == '0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_digit <= '0;
        end else begin
            r_digit <= w_digit_next;
        end
    end

    assign o_digit  = r_digit;
    assign o_at_max = (r_digit == BCD_MAX);
    assign o_at_min = (r_digit == '0);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// NDIG-digit BCD up/down counter with parallel load, wrap or saturate at the limits.
// Parameters:
//   NDIG     : number of BCD digits (1..8)
//   SATURATE : 0 wraps at 0/all-9s, 1 holds at the limits
// Ports:
//   clock, rst : clock, synchronous active-high reset
//   bus        : slave side of bcd_updown_counter_n_if
//                (en, up, load, load_val in; digits, tc, load_err, is_zero out)
// Priority per clock: rst, load, en. tc and load_err are registered one-cycle pulses;
// is_zero is combinational from the digit registers.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic                         clock,
    input  logic                         rst,
    bcd_updown_counter_n_if.slave        bus
);

    if (NDIG < NDIG_MIN || NDIG > NDIG_MAX) begin : g_bad_ndig
        $error("bcd_updown_counter_n: NDIG out of range");
    end

    logic [NDIG:0]   w_carry;   // w_carry[k]: digits 0..k-1 all at 9
    logic [NDIG:0]   w_borrow;  // w_borrow[k]: digits 0..k-1 all at 0
    logic [NDIG-1:0] w_at_max;
    logic [NDIG-1:0] w_at_min;
    logic            w_all_max;
    logic            w_all_min;
    logic            w_step;
    logic            w_inc;
    logic            w_dec;
    logic            w_any_bad;
    logic            w_tc_next;
    logic            w_load_err_next;
    logic            r_tc;
    logic            r_load_err;

    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .clock    (clock),
            .rst      (rst),
            .i_inc    (w_inc),
            .i_dec    (w_dec),
            .i_load   (bus.load),
            .i_ld_val (bus.load_val[4*k +: 4]),
            .i_max_in (w_carry[k]),
            .i_min_in (w_borrow[k]),
            .o_digit  (bus.digits[4*k +: 4]),
            .o_at_max (w_at_max[k]),
            .o_at_min (w_at_min[k])
        );

        assign w_carry[k+1]  = w_carry[k] & w_at_max[k];
        assign w_borrow[k+1] = w_borrow[k] & w_at_min[k];
    end

    assign w_all_max = w_carry[NDIG];
    assign w_all_min = w_borrow[NDIG];

    // Load beats en; in saturate mode a step at the limit is suppressed but still flags tc.
    assign w_step = bus.en & ~bus.load;
    assign w_inc  = w_step &  bus.up & ~((SATURATE != 0) & w_all_max);
    assign w_dec  = w_step & ~bus.up & ~((SATURATE != 0) & w_all_min);

    always_comb begin
        w_any_bad = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            w_any_bad = w_any_bad | bcd_invalid(bus.load_val[4*k +: 4]);
        end
    end

    assign w_tc_next       = w_step & (bus.up ? w_all_max : w_all_min);
    assign w_load_err_next = bus.load & w_any_bad;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tc       <= w_tc_next;
            r_load_err <= w_load_err_next;
        end
    end

    assign bus.tc       = r_tc;
    assign bus.load_err = r_load_err;
    assign bus.is_zero  = w_all_min;

endmodule
